// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: hex font, segment
// bit positions and scan FSM states.
package seg7_pkg;

  // Segment bit positions inside the 8-bit pattern.
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high g..a patterns; element 0 is glyph '0', listed from 'F' down.
  localparam logic [15:0][6:0] FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    StBlank,
    StOn
  } scan_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load-side bus of the scanner: data/dp to capture, level load request and
// the one-cycle acknowledge returned on the capturing frame boundary.
interface seg7_scan_ctrl_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                load_ack;

  modport master (
    output data_in,
    output dp_in,
    output load,
    input  load_ack
  );

  modport slave (
    input  data_in,
    input  dp_in,
    input  load,
    output load_ack
  );

endinterface

// File: rtl/seg7_hex_font.sv
// Combinational hex nibble + decimal point to active-high segment pattern.
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  // Table lookup; dp passes straight through to its own bit.
  always_comb begin
    pattern               = '0;
    pattern[SEG_G:SEG_A]  = FONT[nibble];
    pattern[SEG_DP]       = dp;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Parametrised multiplexed 7-segment scanner with frame-synchronous
// double-buffered load, blanking guard between slots, PWM brightness and
// leading-zero blanking. Define SEG7_BLINK_EN to add per-digit blinking
// (blink_mask port, BLINK_FRAMES parameter).
// BLANK_CYC must be at least 1 and below CLK_HZ/SCAN_HZ.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned CS_ACTIVE_LOW  = 1,
  parameter int unsigned BRIGHT_W       = 4,
  parameter int unsigned LZ_BLANK       = 1
`ifdef SEG7_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES   = 250
`endif
) (
  input  logic                clk50m,
  input  logic                rst,
  seg7_scan_ctrl_if.slave     bus,
  input  logic [BRIGHT_W-1:0] brightness,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]   blink_mask,
`endif
  output logic [7:0]          seg7,
  output logic [DIGITS-1:0]   seg_cs,
  output logic                frame_tick
);

  localparam int unsigned SLOT   = CLK_HZ / SCAN_HZ;
  localparam int unsigned SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SLOT_W-1:0] BlankLast = SLOT_W'(BLANK_CYC - 1);
  localparam logic [SLOT_W-1:0] SlotLast  = SLOT_W'(SLOT - 1);
  localparam logic [IDX_W-1:0]  DigitLast = IDX_W'(DIGITS - 1);

  scan_state_e         state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    digit_q, digit_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [BRIGHT_W-1:0] bright_q;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;

  logic                load_ack;
  logic [DIGITS-1:0]   lz;
  logic [DIGITS-1:0]   hide_vec;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic [7:0]          font_pat;
  logic [7:0]          seg_act;
  logic [DIGITS-1:0]   cs_act;
  logic                cs_on;

  // Scan state, slot position, digit index and PWM phase registers.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q <= StBlank;
      slot_q  <= '0;
      digit_q <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      pwm_q   <= pwm_d;
    end
  end

  // Slot sequencing: guard phase, then lit phase, then advance to next digit.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q + SLOT_W'(1);
    digit_d = digit_q;
    pwm_d   = pwm_q;
    unique case (state_q)
      StBlank: begin
        pwm_d = '0;
        if (slot_q == BlankLast) state_d = StOn;
      end
      StOn: begin
        pwm_d = pwm_q + BRIGHT_W'(1);
        if (slot_q == SlotLast) begin
          state_d = StBlank;
          slot_d  = '0;
          digit_d = (digit_q == DigitLast) ? '0 : digit_q + IDX_W'(1);
        end
      end
    endcase
  end

  // Frame boundary and handshake; a reset cycle never acknowledges a load.
  always_comb begin
    frame_tick   = !rst && (state_q == StOn) && (slot_q == SlotLast) &&
                   (digit_q == DigitLast);
    load_ack     = frame_tick && bus.load;
    bus.load_ack = load_ack;
  end

  // Shadow display registers and per-slot brightness latch.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      data_q   <= '0;
      dp_q     <= '0;
      bright_q <= '0;
    end else begin
      if (load_ack) begin
        data_q <= bus.data_in;
        dp_q   <= bus.dp_in;
      end
      if (state_q == StBlank && slot_q == '0) bright_q <= brightness;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BF_W-1:0] blink_cnt_q;
  logic            hidden_q;

  // Frame counter toggling the blink phase; reset leaves digits visible.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        hidden_q    <= !hidden_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BF_W'(1);
      end
    end
  end

  // Masked digits stay dark for the whole hidden phase.
  always_comb begin
    hide_vec = hidden_q ? blink_mask : '0;
  end
`else
  // Without blinking every digit is always shown.
  always_comb begin
    hide_vec = '0;
  end
`endif

  // Leading-zero map: a digit blanks when it and every higher nibble are zero.
  always_comb begin
    logic upper_zero;
    lz         = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (data_q[4*i +: 4] == 4'h0);
      lz[i]      = upper_zero && (i != 0) && (LZ_BLANK != 0);
    end
  end

  // Select the current digit's nibble, dp and blank flag.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_q == IDX_W'(i)) begin
        cur_nib = data_q[4*i +: 4];
        cur_dp  = dp_q[i];
        cur_lz  = lz[i];
      end
    end
  end

  seg7_hex_font u_font (
    .nibble  (cur_nib),
    .dp      (cur_dp),
    .pattern (font_pat)
  );

  // Active-high drive: pattern held for all of ON, only the select is PWM-gated.
  always_comb begin
    seg_act = '0;
    cs_act  = '0;
    cs_on   = (state_q == StOn) && (pwm_q <= bright_q);
    if (state_q == StOn) begin
      seg_act = font_pat;
      if (cur_lz) seg_act[SEG_G:SEG_A] = '0;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_q == IDX_W'(i)) cs_act[i] = cs_on && !hide_vec[i];
    end
  end

  // Pin polarity applied last.
  always_comb begin
    seg7   = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    seg_cs = (CS_ACTIVE_LOW != 0) ? ~cs_act : cs_act;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment display controller: successor to the fixed 4-digit scanner on the EP4CE6 board top.
- Generalises digit count, scan rate, output polarity and hex decoding.
- Adds behaviour the fixed scanner lacks: frame-synchronous double-buffered load handshake, anti-ghost blanking guard, PWM brightness, leading-zero blanking.
- Instantiated by the board top; drives seg7/seg_cs pins directly.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- CLK_HZ, 50000000, input clock frequency.
- SCAN_HZ, 1000, per-digit slot rate; SLOT = CLK_HZ/SCAN_HZ cycles per slot.
- BLANK_CYC, 500, guard cycles at slot start with all selects off; must be < SLOT.
- SEG_ACTIVE_LOW, 1, 1 = segment pins active low.
- CS_ACTIVE_LOW, 1, 1 = digit selects active low.
- BRIGHT_W, 4, brightness input width.
- LZ_BLANK, 1, 1 = leading-zero blanking enabled.

Ports:
- clk50m  in  1  system clock
- rst  in  1  synchronous, active-high reset
- data_in  in  4*DIGITS  hex nibbles; nibble i shown on digit i; digit 0 = rightmost
- dp_in  in  DIGITS  decimal point per digit
- load  in  1  level request to capture data_in/dp_in; hold until load_ack
- load_ack  out  1  one-cycle pulse: shadow registers updated
- brightness  in  BRIGHT_W  PWM duty; sampled at each slot start
- seg7  out  8  bit0..6 = a..g, bit7 = dp
- seg_cs  out  DIGITS  digit selects, one-hot when active
- frame_tick  out  1  one-cycle pulse on last cycle of each frame

Behaviour:
- Reset values: seg7 = all inactive (8'hFF if SEG_ACTIVE_LOW); seg_cs = all inactive; load_ack = 0; frame_tick = 0; shadow data/dp = 0; digit index = 0; state = BLANK; slot counter = 0.
- Reset mid-operation: outputs inactive on the cycle after rst is sampled high; the in-progress load is discarded, so no ack is issued.
- FSM per slot:
  - BLANK: BLANK_CYC cycles; seg_cs inactive, seg7 inactive.
  - ON: SLOT-BLANK_CYC cycles; the last ON cycle returns to BLANK and advances the digit index.
- Digit index counts 0..DIGITS-1 and wraps to 0.
- Frame = DIGITS slots; frame_tick is high on the last ON cycle of digit DIGITS-1.
- PWM in ON:
  - pwm_cnt (BRIGHT_W bits) free-runs from 0 at ON entry.
  - Select active when pwm_cnt <= latched brightness.
  - Duty = (brightness+1)/2^BRIGHT_W; max value = 100%.
  - seg7 holds the decoded pattern for the whole ON phase; only seg_cs is gated.
- Load handshake:
  - If load = 1 on the frame_tick cycle, the shadow registers capture data_in/dp_in and load_ack pulses in that same cycle.
  - New data is displayed from digit 0 of the next frame, so there is no tearing.
  - load deasserted before frame_tick: nothing captured, no ack.
  - load held after ack: captured again next frame (level semantics).
- Font (active-high, bits g..a), nibbles 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Leading-zero blanking: with LZ_BLANK = 1, digit i > 0 has a..g off when its nibble and all more-significant nibbles are 0. Digit 0 is never blanked. dp is still driven per dp_in.
- Polarity: inversion is applied last, per the SEG_ACTIVE_LOW and CS_ACTIVE_LOW parameters.

Optional Feature:
- Macro SEG7_BLINK_EN.
- Defined:
  - Adds input port blink_mask[DIGITS] and parameter BLINK_FRAMES (default 250).
  - A frame counter toggles a blink phase every BLINK_FRAMES frame_ticks; the phase resets to "visible".
  - During the hidden phase, masked digits keep seg_cs inactive for their entire slot.
- Undefined: the port, parameter and counter are absent; all digits are always shown.

Decomposition:
- Package seg7_pkg:
  - 16-entry font constant;
  - segment bit-index constants (SEG_A..SEG_G, SEG_DP);
  - FSM state enum (BLANK, ON).
- Sub-module seg7_hex_font: combinational nibble+dp -> 8-bit active-high pattern.
- The scanner FSM, counters and handshake stay in seg7_scan_ctrl.

Test Plan:
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (SLOT=10), BLANK_CYC=2, DIGITS=4, BRIGHT_W=2, active-low.
- Reset: rst high 3 cycles -> seg_cs=4'b1111, seg7=8'hFF, load_ack=0. After release: cycles 0-1 blank; cycle 2 seg_cs=4'b1110, seg7=8'hC0 ('0').
- Load: data_in=16'h12AF, dp_in=4'b0010, load held, brightness=3 -> load_ack only on a frame_tick cycle (every 40 cycles).
  - Next frame: digit0 seg7=8'h8E, digit1 = 8'h08 ('A' + dp), digit2 = 8'hA4, digit3 = 8'hF9.
- LZ blanking: load 16'h0030 -> digits 3, 2 seg7=8'hFF with cs active; digit1 = 8'hB0; digit0 = 8'hC0.
- Brightness=1: in each 8-cycle ON phase, cs active when pwm_cnt is 0 or 1 -> pattern 1100_1100 (4 of 8 cycles).
- Aborted load / mid-frame reset:
  - load pulsed 5 cycles mid-frame -> no ack, display unchanged.
  - rst at cycle 17 -> next cycle outputs inactive, shadow cleared, display shows '0'.
- SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 -> digit0 cs active frames 0-1, inactive frames 2-3; other digits always active.
